alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter: WIDTH, default 4, operand/result width in bits (legal range 2..32).
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 in_valid  in  1  operation request present.
REQ-005 in_ready  out  1  block can accept a request this cycle.
REQ-006 in_op  in  4  opcode per REQ-011.
REQ-007 in_a, in_b  in  WIDTH  operands, two's complement where signed.
REQ-008 out_valid  out  1  result registers hold an undelivered result.
REQ-009 out_ready  in  1  consumer accepts the result this cycle.
REQ-010 out_res (WIDTH), out_zero, out_carry, out_overflow, out_err (1 each)  out  result and flags, stable while out_valid=1.

Function
REQ-011 Opcodes: 0000 ADD a+b; 0001 SUB a-b; 0010 NOT ~a; 0011 AND; 0100 OR; 0101 XOR; 0110 LT, signed a<b -> 1 else 0; 0111 EQ, a==b -> 1 else 0; 1000 MUL, unsigned, low WIDTH bits; 1001-1111 illegal.
REQ-012 Handshake: a request is accepted on a cycle with in_valid=1 and in_ready=1; operands and opcode are captured on that edge, and later input changes have no effect.
REQ-013 Delivery: the result is consumed on a cycle with out_valid=1 and out_ready=1; out_res and all flags hold unchanged until that cycle.
REQ-014 FSM states: IDLE, BUSY, HOLD.
- IDLE: in_ready=1, out_valid=0.
- BUSY: MUL in progress; in_ready=0, out_valid=0.
- HOLD: out_valid=1; in_ready=out_ready.
REQ-015 Transitions:
- IDLE, accept non-MUL -> HOLD next cycle (latency 1).
- IDLE, accept MUL -> BUSY.
- BUSY -> HOLD after exactly WIDTH cycles (MUL latency WIDTH+1).
- HOLD, out_ready=0 -> HOLD.
- HOLD, out_ready=1 and no accept -> IDLE.
- HOLD, out_ready=1 with accept -> HOLD (non-MUL) or BUSY (MUL); back-to-back throughput is one non-MUL op per cycle.
REQ-016 MUL is computed by a shift-add algorithm, one multiplier bit per cycle, using a 2*WIDTH-bit accumulator; no WIDTH x WIDTH combinational multiplier is permitted.
REQ-017 ADD: carry = carry-out bit WIDTH; overflow = signed overflow (operands of equal sign, result of differing sign).
REQ-018 SUB: computed as a + ~b + 1; carry = carry-out (1 means no borrow); overflow = signed overflow.
REQ-019 LT: uses the true signed comparison, correct even when a-b overflows; LT and EQ return zero-extended 1 or 0.
REQ-020 MUL: overflow = 1 when the upper WIDTH product bits are nonzero; carry = 0.
REQ-021 NOT, AND, OR, XOR, LT, EQ: carry=0, overflow=0.
REQ-022 zero = (out_res == 0) for every opcode.
REQ-023 Illegal opcode: out_res=0, out_err=1, zero=1, carry=0, overflow=0, latency 1; out_err=0 for all legal opcodes.

Reset
REQ-024 While rst=1: state=IDLE; out_valid=0; out_res=0; all flags=0; MUL accumulator and counter=0. The reset acts immediately, independent of clk.
REQ-025 Reset asserted during BUSY or HOLD discards the operation and produces no result; in_ready=1 on the first cycle after rst deasserts.

Structure
REQ-026 A shared package holds the 4-bit opcode constants and the FSM state type.
REQ-027 The shift-add multiplier is one sub-module, alu_seq_mul, with start/done signals and a WIDTH parameter; all other ops are combinational inside alu_seq and are registered into the output stage.

Verification
REQ-028 WIDTH=4, ADD a=0111 b=0001 -> one cycle later out_res=1000, overflow=1, carry=0, zero=0.
REQ-029 WIDTH=4, SUB a=0011 b=0011 -> out_res=0000, zero=1, carry=1, overflow=0; LT a=1000 b=0111 -> out_res=0001.
REQ-030 WIDTH=4, MUL a=0101 b=0011 -> out_valid rises exactly 5 cycles after accept, out_res=1111, overflow=0; MUL 1111*0010 -> out_res=1110, overflow=1.
REQ-031 Back-to-back: out_ready held 1, four ADDs on consecutive cycles -> four consecutive out_valid cycles with no dropped or duplicated result.
REQ-032 Backpressure: out_ready=0 for 3 cycles in HOLD -> in_ready=0 and out_res stable; out_ready=1 -> result delivered once.
REQ-033 rst pulsed mid-MUL (BUSY cycle 2) -> out_valid=0 and outputs 0 immediately, IDLE after release; illegal opcode 1100 -> out_err=1, out_res=0.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequential ALU: opcode encodings and FSM states.
package alu_seq_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_NOT = 4'b0010;
    localparam logic [3:0] OP_AND = 4'b0011;
    localparam logic [3:0] OP_OR  = 4'b0100;
    localparam logic [3:0] OP_XOR = 4'b0101;
    localparam logic [3:0] OP_LT  = 4'b0110;
    localparam logic [3:0] OP_EQ  = 4'b0111;
    localparam logic [3:0] OP_MUL = 4'b1000;

    // IDLE waits for work, BUSY runs the multiplier, HOLD presents a result.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/alu_seq_mul.sv
// Shift-add multiplier: one multiplier bit per cycle into a 2*WIDTH accumulator.
// done_o is high during the last step; product_o already includes that step,
// so the caller can register the final product on the same edge.
module alu_seq_mul #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               done_o,
    output logic [2*WIDTH-1:0] product_o
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [CW-1:0]      count_q;
    logic [2*WIDTH-1:0] accNext;

    // Partial product for the current multiplier bit added to the running sum.
    always_comb begin
        accNext = acc_q + (mplier_q[0] ? mcand_q : '0);
    end

    assign product_o = accNext;
    assign done_o    = (count_q == CW'(1));

    // Load operands on start, then shift one bit per cycle until the count runs out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
        end else if (start_i) begin
            mcand_q  <= {{WIDTH{1'b0}}, a_i};
            mplier_q <= b_i;
            acc_q    <= '0;
            count_q  <= CW'(WIDTH);
        end else if (count_q != '0) begin
            acc_q    <= accNext;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            count_q  <= count_q - CW'(1);
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshakes on both sides. Single-cycle ops
// are computed from the request inputs and registered on the accept edge;
// MUL is handed to the shift-add multiplier and registered when it finishes.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic             out_zero,
    output logic             out_carry,
    output logic             out_overflow,
    output logic             out_err
);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   outRes_q;
    logic               outZero_q, outCarry_q, outOverflow_q, outErr_q;

    logic [WIDTH:0]     addSum, subSum;
    logic [WIDTH-1:0]   aluRes;
    logic               aluCarry, aluOvf, aluErr;
    logic               accept, isMul, mulStart, loadAlu, loadMul;
    logic               mulDone;
    logic [2*WIDTH-1:0] mulProduct;

    alu_seq_mul #(.WIDTH(WIDTH)) uMul (
        .clk       (clk),
        .rst       (rst),
        .start_i   (mulStart),
        .a_i       (in_a),
        .b_i       (in_b),
        .done_o    (mulDone),
        .product_o (mulProduct)
    );

    // Single-cycle datapath; SUB is a + ~b + 1 so carry-out means no borrow.
    always_comb begin
        addSum   = {1'b0, in_a} + {1'b0, in_b};
        subSum   = {1'b0, in_a} + {1'b0, ~in_b} + {{WIDTH{1'b0}}, 1'b1};
        aluRes   = '0;
        aluCarry = 1'b0;
        aluOvf   = 1'b0;
        aluErr   = 1'b0;
        case (in_op)
            OP_ADD: begin
                aluRes   = addSum[WIDTH-1:0];
                aluCarry = addSum[WIDTH];
                aluOvf   = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (addSum[WIDTH-1] != in_a[WIDTH-1]);
            end
            OP_SUB: begin
                aluRes   = subSum[WIDTH-1:0];
                aluCarry = subSum[WIDTH];
                aluOvf   = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (subSum[WIDTH-1] != in_a[WIDTH-1]);
            end
            OP_NOT:  aluRes = ~in_a;
            OP_AND:  aluRes = in_a & in_b;
            OP_OR:   aluRes = in_a | in_b;
            OP_XOR:  aluRes = in_a ^ in_b;
            OP_LT:   aluRes = {{(WIDTH-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
            OP_EQ:   aluRes = {{(WIDTH-1){1'b0}}, (in_a == in_b)};
            OP_MUL:  aluRes = '0;
            default: aluErr = 1'b1;
        endcase
    end

    // Handshake outputs, load strobes and next state.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ST_IDLE: in_ready = 1'b1;
            ST_HOLD: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
            end
            default: ;
        endcase
        isMul    = (in_op == OP_MUL);
        accept   = in_valid && in_ready;
        mulStart = accept && isMul;
        loadAlu  = accept && !isMul;
        loadMul  = (state_q == ST_BUSY) && mulDone;
        case (state_q)
            ST_IDLE: if (accept) state_d = isMul ? ST_BUSY : ST_HOLD;
            ST_BUSY: if (mulDone) state_d = ST_HOLD;
            ST_HOLD: if (out_ready) state_d = accept ? (isMul ? ST_BUSY : ST_HOLD) : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State register and result stage; the result only changes on a load strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            outRes_q      <= '0;
            outZero_q     <= 1'b0;
            outCarry_q    <= 1'b0;
            outOverflow_q <= 1'b0;
            outErr_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (loadAlu) begin
                outRes_q      <= aluRes;
                outZero_q     <= (aluRes == '0);
                outCarry_q    <= aluCarry;
                outOverflow_q <= aluOvf;
                outErr_q      <= aluErr;
            end else if (loadMul) begin
                outRes_q      <= mulProduct[WIDTH-1:0];
                outZero_q     <= (mulProduct[WIDTH-1:0] == '0);
                outCarry_q    <= 1'b0;
                outOverflow_q <= |mulProduct[2*WIDTH-1:WIDTH];
                outErr_q      <= 1'b0;
            end
        end
    end

    assign out_res      = outRes_q;
    assign out_zero     = outZero_q;
    assign out_carry    = outCarry_q;
    assign out_overflow = outOverflow_q;
    assign out_err      = outErr_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq at WIDTH=4: directed vectors with literal expectations plus
// an arithmetic reference model feeding a scoreboard checked every output cycle.
module tb_alu_seq;
    import alu_seq_pkg::*;

    localparam int W = 4;

    typedef struct packed {
        logic [W-1:0] res;
        logic         zero;
        logic         carry;
        logic         ovf;
        logic         err;
    } exp_t;

    logic         clk, rst;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [3:0]   in_op;
    logic [W-1:0] in_a, in_b, out_res;
    logic         out_zero, out_carry, out_overflow, out_err;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t cmpExp;

    alu_seq #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_op        (in_op),
        .in_a         (in_a),
        .in_b         (in_b),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_res      (out_res),
        .out_zero     (out_zero),
        .out_carry    (out_carry),
        .out_overflow (out_overflow),
        .out_err      (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Reference model using plain integer arithmetic on the operand values.
    function automatic exp_t modelAlu(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t   e;
        longint full, ua, ub, sa, sb_, r, smax, smin;
        full = longint'(1) << W;
        smax = full / 2 - 1;
        smin = -(full / 2);
        ua   = longint'(a);
        ub   = longint'(b);
        sa   = (ua > smax) ? ua - full : ua;
        sb_  = (ub > smax) ? ub - full : ub;
        e    = '0;
        r    = 0;
        case (op)
            4'd0: begin
                r       = ua + ub;
                e.carry = (r >= full);
                e.ovf   = (sa + sb_ > smax) || (sa + sb_ < smin);
            end
            4'd1: begin
                r       = ua - ub + full;
                e.carry = (ua >= ub);
                e.ovf   = (sa - sb_ > smax) || (sa - sb_ < smin);
            end
            4'd2: r = full - 1 - ua;
            4'd3: r = ua & ub;
            4'd4: r = ua | ub;
            4'd5: r = ua ^ ub;
            4'd6: r = (sa < sb_) ? 1 : 0;
            4'd7: r = (ua == ub) ? 1 : 0;
            4'd8: begin
                r     = ua * ub;
                e.ovf = (r >= full);
            end
            default: e.err = 1'b1;
        endcase
        e.res  = r[W-1:0];
        e.zero = (e.res == '0);
        return e;
    endfunction

    // Compare process: outputs against the scoreboard head on every valid cycle.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            checkOutput("rstOutValid", longint'(out_valid), 0);
            checkOutput("rstOutRes", longint'(out_res), 0);
            checkOutput("rstFlags", longint'({out_zero, out_carry, out_overflow, out_err}), 0);
        end else begin
            if (out_valid) begin
                checkOutput("holdInReady", longint'(in_ready), longint'(out_ready));
                checkOutput("resultPending", longint'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    cmpExp = sb[0];
                    checkOutput("res", longint'(out_res), longint'(cmpExp.res));
                    checkOutput("zero", longint'(out_zero), longint'(cmpExp.zero));
                    checkOutput("carry", longint'(out_carry), longint'(cmpExp.carry));
                    checkOutput("overflow", longint'(out_overflow), longint'(cmpExp.ovf));
                    checkOutput("err", longint'(out_err), longint'(cmpExp.err));
                    if (out_ready) void'(sb.pop_front());
                end
            end
            if (in_valid && in_ready) sb.push_back(modelAlu(in_op, in_a, in_b));
        end
    end

    // Issue one request, scramble inputs after acceptance, wait for its result.
    task automatic applyStimulus(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output int lat);
        int n = 0;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("acceptWait", longint'(n < 50), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_op    = 4'b1111;
        in_a     = ~a;
        in_b     = ~b;
        lat      = 1;
        while (!out_valid && lat < 50) begin
            checkOutput("busyInReady", longint'(in_ready), 0);
            @(posedge clk); #1;
            lat++;
        end
    endtask

    logic [3:0]   vOp[11] = '{OP_NOT, OP_AND, OP_OR, OP_XOR, OP_EQ, OP_EQ, OP_ADD, OP_SUB, OP_SUB, OP_LT, OP_MUL};
    logic [W-1:0] vA[11]  = '{4'b0101, 4'b1100, 4'b1100, 4'b1100, 4'b1001, 4'b1001, 4'b1000, 4'b0000, 4'b1000, 4'b0111, 4'b0000};
    logic [W-1:0] vB[11]  = '{4'b0000, 4'b1010, 4'b0101, 4'b1010, 4'b1001, 4'b1000, 4'b1000, 4'b0001, 4'b0001, 4'b1000, 4'b1011};

    initial begin
        int lat;
        int validCnt;
        int quietCnt;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_op     = 4'd0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("resetInReady", longint'(in_ready), 1);
        checkOutput("resetOutValid", longint'(out_valid), 0);
        rst = 1'b0;
        @(posedge clk); #1;
        checkOutput("idleInReady", longint'(in_ready), 1);

        applyStimulus(OP_ADD, 4'b0111, 4'b0001, lat);
        checkOutput("addLatency", lat, 1);
        checkOutput("addRes", longint'(out_res), 8);
        checkOutput("addOverflow", longint'(out_overflow), 1);
        checkOutput("addCarry", longint'(out_carry), 0);
        checkOutput("addZero", longint'(out_zero), 0);

        applyStimulus(OP_SUB, 4'b0011, 4'b0011, lat);
        checkOutput("subRes", longint'(out_res), 0);
        checkOutput("subZero", longint'(out_zero), 1);
        checkOutput("subCarry", longint'(out_carry), 1);
        checkOutput("subOverflow", longint'(out_overflow), 0);

        applyStimulus(OP_LT, 4'b1000, 4'b0111, lat);
        checkOutput("ltRes", longint'(out_res), 1);

        applyStimulus(OP_MUL, 4'b0101, 4'b0011, lat);
        checkOutput("mulLatency", lat, W + 1);
        checkOutput("mulRes", longint'(out_res), 15);
        checkOutput("mulOverflow", longint'(out_overflow), 0);

        applyStimulus(OP_MUL, 4'b1111, 4'b0010, lat);
        checkOutput("mulOvfRes", longint'(out_res), 14);
        checkOutput("mulOvfOverflow", longint'(out_overflow), 1);
        checkOutput("mulOvfCarry", longint'(out_carry), 0);

        for (int i = 0; i < 11; i++) begin
            applyStimulus(vOp[i], vA[i], vB[i], lat);
            checkOutput("tableLatency", lat, (vOp[i] == OP_MUL) ? W + 1 : 1);
        end

        // Back-to-back ADDs with the consumer always ready.
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        validCnt = 0;
        for (int i = 0; i < 4; i++) begin
            in_op    = OP_ADD;
            in_a     = W'(i + 1);
            in_b     = W'(2 * i + 3);
            in_valid = 1'b1;
            @(posedge clk); #1;
            validCnt += int'(out_valid);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        checkOutput("b2bValidCycles", validCnt, 4);
        checkOutput("b2bDrained", longint'(out_valid), 0);

        // Backpressure: result must hold while the consumer stalls.
        out_ready = 1'b0;
        applyStimulus(OP_ADD, 4'b0010, 4'b0011, lat);
        checkOutput("bpLatency", lat, 1);
        in_op    = OP_XOR;
        in_a     = 4'b1111;
        in_b     = 4'b0001;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checkOutput("bpValid", longint'(out_valid), 1);
            checkOutput("bpInReady", longint'(in_ready), 0);
            checkOutput("bpRes", longint'(out_res), 5);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("bpDeliveredOnce", longint'(out_valid), 0);

        // Reset in the second BUSY cycle of a multiply.
        in_op    = OP_MUL;
        in_a     = 4'b0111;
        in_b     = 4'b0111;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checkOutput("mulBusyValid", longint'(out_valid), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checkOutput("midRstValid", longint'(out_valid), 0);
        checkOutput("midRstRes", longint'(out_res), 0);
        checkOutput("midRstFlags", longint'({out_zero, out_carry, out_overflow, out_err}), 0);
        checkOutput("midRstInReady", longint'(in_ready), 1);
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("postRstInReady", longint'(in_ready), 1);
        quietCnt = 0;
        for (int i = 0; i < W + 3; i++) begin
            @(posedge clk); #1;
            quietCnt += int'(out_valid);
        end
        checkOutput("postRstNoResult", quietCnt, 0);

        applyStimulus(4'b1100, 4'b0110, 4'b0011, lat);
        checkOutput("illegalLatency", lat, 1);
        checkOutput("illegalErr", longint'(out_err), 1);
        checkOutput("illegalRes", longint'(out_res), 0);
        checkOutput("illegalZero", longint'(out_zero), 1);

        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("scoreboardDrained", longint'(sb.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Guard against a stuck handshake.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
